// File: rtl/project_ugpe_pkg.sv
// Shared definitions for the ungapped-extension PE: window message layout,
// FSM states, store indices and the window-length clamp.
package project_ugpe_pkg;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  localparam int unsigned LEN_LSB    = 112;
  localparam int unsigned DSTART_LSB = 80;
  localparam int unsigned QSTART_LSB = 64;

  typedef struct packed {
    logic [31:0] scoreaddr;
    logic [31:0] lenaddr;
    logic [31:0] dposaddr;
    logic [31:0] qposaddr;
    logic [15:0] len;
    logic [15:0] hit;
    logic [15:0] dstart;
    logic [15:0] qstart;
    logic [31:0] d;
    logic [31:0] q;
  } ugpe_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    EXTEND,
    ST_REQ,
    ST_RESP
  } ugpe_state_t;

  localparam logic [1:0] K_SCORE = 2'd0;
  localparam logic [1:0] K_LEN   = 2'd1;
  localparam logic [1:0] K_DPOS  = 2'd2;
  localparam logic [1:0] K_QPOS  = 2'd3;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] len);
    return (len > 16'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/project_ugpe_score_step.sv
// One extension step: compare a base pair, update running/best score and
// best length, and flag an X-drop termination.
module project_ugpe_score_step
  import project_ugpe_pkg::*;
#(
  parameter int MATCH_SCORE    = 1,
  parameter int MISMATCH_SCORE = -1,
  parameter int XDROP          = 4,
  parameter int SCORE_W        = 16
) (
  input  logic [1:0]                d_base,
  input  logic [1:0]                q_base,
  input  logic [LEN_W-1:0]          idx,
  input  logic signed [SCORE_W-1:0] run,
  input  logic signed [SCORE_W-1:0] best,
  input  logic [LEN_W-1:0]          blen,
  output logic signed [SCORE_W-1:0] run_next,
  output logic signed [SCORE_W-1:0] best_next,
  output logic [LEN_W-1:0]          blen_next,
  output logic                      drop
);

  localparam logic signed [SCORE_W-1:0] MATCH_V    = SCORE_W'(MATCH_SCORE);
  localparam logic signed [SCORE_W-1:0] MISMATCH_V = SCORE_W'(MISMATCH_SCORE);
  localparam logic signed [SCORE_W-1:0] XDROP_V    = SCORE_W'(XDROP);

  always_comb begin
    run_next  = run + ((d_base == q_base) ? MATCH_V : MISMATCH_V);
    best_next = best;
    blen_next = blen;
    // strict compare: an equal later score keeps the shorter extension
    if (run_next > best) begin
      best_next = run_next;
      blen_next = idx + LEN_W'(1);
    end
    drop = (best_next - run_next) > XDROP_V;
  end

endmodule

// File: rtl/project_ungapped_ext.sv
// Ungapped-extension PE: accepts a packed hit window, extends with X-drop,
// then writes score/length/dstart/qstart as four sequential stores.
module project_ungapped_ext
  import project_ugpe_pkg::*;
#(
  parameter int MATCH_SCORE    = 1,
  parameter int MISMATCH_SCORE = -1,
  parameter int XDROP          = 4,
  parameter int SCORE_W        = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] istream_msg,
  input  logic         istream_val,
  output logic         istream_rdy,
  output logic [63:0]  memreq_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  input  logic [31:0]  memresp_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  output logic         done
);

  ugpe_state_t state, state_n;
  ugpe_msg_t   in_msg, win;

  logic [LEN_W-1:0]          len_c, i, blen, blen_n;
  logic [1:0]                k;
  logic signed [SCORE_W-1:0] run, best, run_n, best_n;
  logic                      drop, last;
  logic [1:0]                d_base, q_base;
  logic                      unused_bits;

  assign in_msg      = istream_msg;
  assign d_base      = win.d[{i[3:0], 1'b0} +: 2];
  assign q_base      = win.q[{i[3:0], 1'b0} +: 2];
  assign last        = (i + LEN_W'(1)) == len_c;
  assign unused_bits = ^{win.len, win.hit, memresp_msg};

  project_ugpe_score_step #(
    .MATCH_SCORE   (MATCH_SCORE),
    .MISMATCH_SCORE(MISMATCH_SCORE),
    .XDROP         (XDROP),
    .SCORE_W       (SCORE_W)
  ) u_step (
    .d_base   (d_base),
    .q_base   (q_base),
    .idx      (i),
    .run      (run),
    .best     (best),
    .blen     (blen),
    .run_next (run_n),
    .best_next(best_n),
    .blen_next(blen_n),
    .drop     (drop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    // gated by reset_n so the ready output is low while reset is held
    istream_rdy = reset_n && (state == IDLE);
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    memreq_msg  = '0;
    case (state)
      IDLE: begin
        if (istream_val) state_n = (clamp_len(in_msg.len) != '0) ? EXTEND : ST_REQ;
      end
      EXTEND: begin
        if (last || drop) state_n = ST_REQ;
      end
      ST_REQ: begin
        memreq_val = 1'b1;
        case (k)
          K_SCORE: memreq_msg = {win.scoreaddr, 32'(best)};
          K_LEN:   memreq_msg = {win.lenaddr,   32'(blen)};
          K_DPOS:  memreq_msg = {win.dposaddr,  32'(win.dstart)};
          default: memreq_msg = {win.qposaddr,  32'(win.qstart)};
        endcase
        if (memreq_rdy) state_n = ST_RESP;
      end
      ST_RESP: begin
        memresp_rdy = 1'b1;
        if (memresp_val) state_n = (k == K_QPOS) ? IDLE : ST_REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win   <= '0;
      len_c <= '0;
      i     <= '0;
      k     <= '0;
      run   <= '0;
      best  <= '0;
      blen  <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == ST_RESP) && memresp_val && (k == K_QPOS);
      case (state)
        IDLE: begin
          if (istream_val) begin
            win   <= in_msg;
            len_c <= clamp_len(in_msg.len);
            i     <= '0;
            k     <= '0;
            run   <= '0;
            best  <= '0;
            blen  <= '0;
          end
        end
        EXTEND: begin
          run  <= run_n;
          best <= best_n;
          blen <= blen_n;
          if (!(last || drop)) i <= i + LEN_W'(1);
        end
        ST_RESP: begin
          if (memresp_val && (k != K_QPOS)) k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_project_ungapped_ext.sv
// Scoreboard bench for project_ungapped_ext: directed and random windows,
// randomized memory back-pressure, mid-extension reset and back-to-back windows.
module tb_project_ungapped_ext;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] istream_msg;
  logic         istream_val;
  logic         istream_rdy;
  logic [63:0]  memreq_msg;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [31:0]  memresp_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int accepted = 0;
  int retired  = 0;
  int req_stall_cfg  = 0;
  int resp_delay_cfg = 0;
  logic [63:0] sb_q[$];

  project_ungapped_ext #(
    .MATCH_SCORE   (1),
    .MISMATCH_SCORE(-1),
    .XDROP         (4),
    .SCORE_W       (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .istream_msg(istream_msg),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .memreq_msg (memreq_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memresp_msg(memresp_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [255:0] mk(input logic [31:0] sa, input logic [31:0] la,
                                      input logic [31:0] da, input logic [31:0] qa,
                                      input logic [15:0] len, input logic [15:0] hit,
                                      input logic [15:0] ds, input logic [15:0] qs,
                                      input logic [31:0] d, input logic [31:0] q);
    return {sa, la, da, qa, len, hit, ds, qs, d, q};
  endfunction

  // Reference: walk the bases, keep the best prefix score, stop on X-drop.
  function automatic void ref_ext(input logic [31:0] d, input logic [31:0] q, input int len,
                                  output int score, output int blen);
    int n, run;
    n = (len > 16) ? 16 : len;
    run = 0; score = 0; blen = 0;
    for (int j = 0; j < n; j++) begin
      run += (d[2*j +: 2] == q[2*j +: 2]) ? 1 : -1;
      if (run > score) begin score = run; blen = j + 1; end
      if (score - run > 4) break;
    end
  endfunction

  task automatic send(input logic [255:0] m, input bit push, input int es, input int el);
    bit ok = 0;
    @(posedge clk); #1;
    istream_msg = m;
    istream_val = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (istream_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no istream_rdy expected rdy within 400 cycles");
    end else if (push) begin
      chk("prev_retired", 64'(sb_q.size()), 64'd0);
      sb_q.push_back({m[255:224], 32'(es)});
      sb_q.push_back({m[223:192], 32'(el)});
      sb_q.push_back({m[191:160], 32'(m[95:80])});
      sb_q.push_back({m[159:128], 32'(m[79:64])});
      accepted++;
    end
    @(posedge clk); #1;
    istream_val = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] d, q;
    logic [15:0] len;
    int s, l;
    q   = $urandom;
    d   = q ^ ($urandom & $urandom & $urandom);
    len = 16'($urandom_range(0, 20));
    ref_ext(d, q, int'(len), s, l);
    send(mk($urandom, $urandom, $urandom, $urandom, len, 16'($urandom),
            16'($urandom), 16'($urandom), d, q), 1, s, l);
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (retired == accepted && sb_q.size() == 0) break;
    end
    chk("retired_count", 64'(retired), 64'(accepted));
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Memory responder: optional request stall and response delay.
  initial begin
    bit req_hs, resp_hs, pending;
    int stall_left, resp_wait;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
    pending = 0; stall_left = 0; resp_wait = 0;
    forever begin
      @(negedge clk);
      req_hs  = memreq_val && memreq_rdy;
      resp_hs = memresp_val && memresp_rdy;
      @(posedge clk); #1;
      if (!reset_n) begin
        pending = 0; memresp_val = 1'b0; memreq_rdy = 1'b0;
        continue;
      end
      if (resp_hs) pending = 0;
      if (req_hs) begin pending = 1; resp_wait = resp_delay_cfg; end
      memresp_val = 1'b0;
      memresp_msg = 32'($urandom);
      if (pending) begin
        if (resp_wait == 0) memresp_val = 1'b1;
        else resp_wait--;
      end
      memreq_rdy = 1'b0;
      if (!memreq_val) stall_left = req_stall_cfg;
      else if (stall_left == 0) memreq_rdy = 1'b1;
      else stall_left--;
    end
  end

  // Monitor: checks every presented store, one-outstanding rule and done timing.
  initial begin
    bit outstanding = 0;
    bit done_due = 0;
    int acks = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin outstanding = 0; done_due = 0; acks = 0; continue; end
      if (done || done_due) chk("done_pulse", 64'(done), 64'(done_due));
      if (done) retired++;
      done_due = 0;
      if (memreq_val) begin
        chk("one_outstanding", 64'(outstanding), 64'd0);
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_store: got %h expected no store", memreq_msg);
        end else begin
          chk("store_msg", memreq_msg, sb_q[0]);
          if (memreq_rdy) begin void'(sb_q.pop_front()); outstanding = 1; end
        end
      end
      if (memresp_val && memresp_rdy) begin
        outstanding = 0;
        acks++;
        if (acks % 4 == 0) done_due = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n = 1'b0; istream_val = 1'b0; istream_msg = '0;
    repeat (3) @(negedge clk);
    chk("rst_istream_rdy", 64'(istream_rdy), 64'd0);
    chk("rst_memreq_val", 64'(memreq_val), 64'd0);
    chk("rst_memresp_rdy", 64'(memresp_rdy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_memreq_msg", memreq_msg, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 64'(istream_rdy), 64'd1);

    send(mk(32'h1000, 32'h1004, 32'h1008, 32'h100C, 16'd16, 16'h1, 16'h11, 16'h22,
            32'h0000_0000, 32'h0000_0000), 1, 16, 16);
    send(mk(32'h2000, 32'h2004, 32'h2008, 32'h200C, 16'd16, 16'h2, 16'h33, 16'h44,
            32'hFFFF_FFFF, 32'h0000_0000), 1, 0, 0);
    send(mk(32'h3000, 32'h3004, 32'h3008, 32'h300C, 16'd16, 16'h3, 16'h55, 16'h66,
            32'hFFFF_FFC0, 32'h0000_0000), 1, 3, 3);
    send(mk(32'h4000, 32'h4004, 32'h4008, 32'h400C, 16'd0, 16'h4, 16'h77, 16'h88,
            32'h0000_0000, 32'h0000_0000), 1, 0, 0);
    send(mk(32'h5000, 32'h5004, 32'h5008, 32'h500C, 16'd20, 16'h5, 16'h99, 16'hAA,
            32'h0000_0000, 32'h0000_0000), 1, 16, 16);
    drain();

    req_stall_cfg = 5; resp_delay_cfg = 3;
    send(mk(32'h100, 32'h104, 32'h108, 32'h10C, 16'd16, 16'h6, 16'h0005, 16'h0009,
            32'hFFFF_FFC0, 32'h0000_0000), 1, 3, 3);
    drain();
    req_stall_cfg = 0; resp_delay_cfg = 0;

    send(mk(32'h6000, 32'h6004, 32'h6008, 32'h600C, 16'd16, 16'h7, 16'h1, 16'h2,
            32'h0, 32'h0), 0, 0, 0);
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_istream_rdy", 64'(istream_rdy), 64'd0);
    chk("abort_memreq_val", 64'(memreq_val), 64'd0);
    chk("abort_memresp_rdy", 64'(memresp_rdy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_memreq_msg", memreq_msg, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(mk(32'h7000, 32'h7004, 32'h7008, 32'h700C, 16'd16, 16'h8, 16'h0123, 16'h0456,
            32'hFFFF_FFC0, 32'h0000_0000), 1, 3, 3);
    drain();

    resp_delay_cfg = 2;
    send(mk(32'h8000, 32'h8004, 32'h8008, 32'h800C, 16'd16, 16'h9, 16'h0A, 16'h0B,
            32'h0, 32'h0), 1, 16, 16);
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (memresp_rdy) begin seen = 1; break; end
    end
    chk("saw_resp_state", 64'(seen), 64'd1);
    chk("busy_not_ready", 64'(istream_rdy), 64'd0);
    send(mk(32'h9000, 32'h9004, 32'h9008, 32'h900C, 16'd16, 16'hA, 16'h0C, 16'h0D,
            32'hFFFF_FFFF, 32'h0), 1, 0, 0);
    drain();

    for (int w = 0; w < 30; w++) begin
      req_stall_cfg  = $urandom_range(0, 3);
      resp_delay_cfg = $urandom_range(0, 3);
      send_rand();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
